// File: rtl/ysyx_220066_mem_arb.sv
// Three-way memory arbiter: dcache writeback > round-robin(icache refill, dcache refill), one transaction at a time.
// Optional BUSY watchdog exists only when YSYX_220066_ARB_TIMEOUT_EN is defined.
module ysyx_220066_mem_arb
  #(parameter int TIMEOUT = 1024)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         ins_req_i,
  input  logic         ins_burst_i,
  input  logic [63:0]  ins_addr_i,
  output logic         ins_ready_o,
  output logic         ins_err_o,
  output logic [511:0] ins_data_o,
  input  logic         rd_req_i,
  input  logic         rd_burst_i,
  input  logic [2:0]   rd_len_i,
  input  logic [63:0]  rd_addr_i,
  output logic         rd_ready_o,
  output logic         rd_err_o,
  output logic [511:0] rd_data_o,
  input  logic         wr_req_i,
  input  logic         wr_burst_i,
  input  logic [2:0]   wr_len_i,
  input  logic [7:0]   wr_mask_i,
  input  logic [63:0]  wr_addr_i,
  input  logic [511:0] wr_data_i,
  output logic         wr_ready_o,
  output logic         wr_err_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic         mem_burst_o,
  output logic [2:0]   mem_len_o,
  output logic [7:0]   mem_mask_o,
  output logic [63:0]  mem_addr_o,
  output logic [511:0] mem_wdata_o,
  input  logic         mem_ready_i,
  input  logic         mem_err_i,
  input  logic [511:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic [1:0] {OWN_INS, OWN_RD, OWN_WR} owner_e;

  state_e         state_q, state_d;
  owner_e         owner_q, owner_d;
  logic           lastRd_q, lastRd_d;
  logic           we_q, we_d;
  logic           burst_q, burst_d;
  logic [2:0]     len_q, len_d;
  logic [7:0]     mask_q, mask_d;
  logic [63:0]    addr_q, addr_d;
  logic [511:0]   wdata_q, wdata_d;
  logic [511:0]   line_q, line_d;
  logic           err_q, err_d;
  logic           timeoutHit;
  logic           respNow;

`ifdef YSYX_220066_ARB_TIMEOUT_EN
  logic [15:0] tmoCnt_q;

  // Counts BUSY cycles; held at zero outside BUSY so every transaction starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmoCnt_q <= '0;
    end else if (state_q != BUSY) begin
      tmoCnt_q <= '0;
    end else begin
      tmoCnt_q <= tmoCnt_q + 16'd1;
    end
  end

  assign timeoutHit = (tmoCnt_q == 16'(TIMEOUT - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_INS;
      lastRd_q <= 1'b1;
      we_q     <= 1'b0;
      burst_q  <= 1'b0;
      len_q    <= '0;
      mask_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      line_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lastRd_q <= lastRd_d;
      we_q     <= we_d;
      burst_q  <= burst_d;
      len_q    <= len_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      line_q   <= line_d;
      err_q    <= err_d;
    end
  end

  // Icache wins a refill tie unless it was the last refill served (lastRd_q == 0).
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    lastRd_d = lastRd_q;
    we_d     = we_q;
    burst_d  = burst_q;
    len_d    = len_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    line_d   = line_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (wr_req_i) begin
          state_d = BUSY;
          owner_d = OWN_WR;
          we_d    = 1'b1;
          burst_d = wr_burst_i;
          len_d   = wr_len_i;
          mask_d  = wr_mask_i;
          addr_d  = wr_addr_i;
          wdata_d = wr_data_i;
        end else if (ins_req_i && (lastRd_q || !rd_req_i)) begin
          state_d = BUSY;
          owner_d = OWN_INS;
          we_d    = 1'b0;
          burst_d = ins_burst_i;
          len_d   = 3'd0;
          mask_d  = 8'd0;
          addr_d  = ins_addr_i;
          wdata_d = '0;
        end else if (rd_req_i) begin
          state_d = BUSY;
          owner_d = OWN_RD;
          we_d    = 1'b0;
          burst_d = rd_burst_i;
          len_d   = rd_len_i;
          mask_d  = 8'd0;
          addr_d  = rd_addr_i;
          wdata_d = '0;
        end
      end
      BUSY: begin
        if (mem_ready_i) begin
          state_d = RESP;
          err_d   = mem_err_i;
          if (!we_q) begin
            line_d = mem_rdata_i;
          end
        end else if (timeoutHit) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (owner_q == OWN_INS) begin
          lastRd_d = 1'b0;
        end else if (owner_q == OWN_RD) begin
          lastRd_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign respNow     = (state_q == RESP);
  assign mem_req_o   = (state_q == BUSY);
  assign mem_we_o    = we_q;
  assign mem_burst_o = burst_q;
  assign mem_len_o   = len_q;
  assign mem_mask_o  = mask_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign ins_ready_o = respNow && (owner_q == OWN_INS);
  assign rd_ready_o  = respNow && (owner_q == OWN_RD);
  assign wr_ready_o  = respNow && (owner_q == OWN_WR);
  assign ins_err_o   = ins_ready_o && err_q;
  assign rd_err_o    = rd_ready_o && err_q;
  assign wr_err_o    = wr_ready_o && err_q;
  assign ins_data_o  = line_q;
  assign rd_data_o   = line_q;

endmodule
